// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: the immsrc format
// encoding and the default datapath width.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101
  } immsrc_e;

endpackage

// File: rtl/imm_stage.sv
// One pipeline slice: a valid bit plus a data word, updated only when the
// slice's load enable is high. Loading an empty upstream slot turns this
// slice into a bubble; the data word is left alone in that case.
module imm_stage #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Capture the upstream slot when enabled; reset empties the slice and zeroes its data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate decode/extend for RV32/RV64 instruction words, followed by a
// DEPTH-deep elastic register pipeline.
// Optional feature macro: IMMEXT_ERRCNT_EN adds err_count, a saturating
// count of illegal-format results handed downstream.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready may depend combinationally on out_ready;
// out_valid/immext/illegal come straight from registers and stay stable
// while out_valid && !out_ready.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic            illegal
`ifdef IMMEXT_ERRCNT_EN
  ,
  output logic [7:0]      err_count
`endif
);

  // The port carries instruction bits [31:7]; B shifts architectural bit
  // numbers onto port indices so the decode below reads like the ISA manual.
  localparam int B = 7;
  localparam int W = XLEN + 1;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            ill;
  logic            sext;

  // Decode the selected format into a 32-bit immediate, then widen to XLEN
  always_comb begin
    imm32 = '0;
    ill   = 1'b0;
    sext  = 1'b1;
    case (immsrc_e'(immsrc))
      IMM_I: imm32 = {{20{instr[31-B]}}, instr[31-B:20-B]};
      IMM_S: imm32 = {{20{instr[31-B]}}, instr[31-B:25-B], instr[11-B:7-B]};
      IMM_B: imm32 = {{19{instr[31-B]}}, instr[31-B], instr[7-B],
                      instr[30-B:25-B], instr[11-B:8-B], 1'b0};
      IMM_J: imm32 = {{11{instr[31-B]}}, instr[31-B], instr[19-B:12-B],
                      instr[20-B], instr[30-B:21-B], 1'b0};
      IMM_U: imm32 = {instr[31-B:12-B], 12'b0};
      IMM_SHAMT: begin
        sext = 1'b0;
        if (XLEN == 64) begin
          imm32 = {26'b0, instr[25-B:20-B]};
        end else begin
          imm32 = {27'b0, instr[24-B:20-B]};
        end
      end
      default: begin
        sext = 1'b0;
        ill  = 1'b1;
      end
    endcase
    // Upper bits replicate instruction bit 31 for signed formats, zero otherwise
    imm        = {XLEN{sext & instr[31-B]}};
    imm[31:0]  = imm32;
  end

  // Slot 0 is the combinational decode; slot k is the output of stage k
  logic [DEPTH:0] vld;
  logic [W-1:0]   dat [DEPTH+1];
  logic [DEPTH-1:0] ld;

  assign vld[0] = in_valid;
  assign dat[0] = {ill, imm};

  // A stage may load when it or any stage downstream of it is empty, or the
  // output side is draining this cycle: that is exactly "empty, or its
  // contents move on in the same cycle", without a ripple through ld.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign ld[i] = out_ready || !(&vld[DEPTH:i+1]);

    imm_stage #(.W(W)) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ld[i]),
      .in_valid  (vld[i]),
      .in_data   (dat[i]),
      .out_valid (vld[i+1]),
      .out_data  (dat[i+1])
    );
  end

  assign in_ready          = ld[0];
  assign out_valid         = vld[DEPTH];
  assign {illegal, immext} = dat[DEPTH];

`ifdef IMMEXT_ERRCNT_EN
  // Count illegal results as they are handed downstream, saturating at 255
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'd0;
    end else if (out_valid && out_ready && illegal && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
